// File: rtl/rectifier.sv
// rectifier: activation stage that sits directly after the product neuron.
//
// Forward path: takes the product's signed Q8.8 result and applies a
// saturating rectifier. It outputs an unsigned Q0.8 activation that the next
// layer can use as a product argument. Negative inputs give 0x00. Inputs
// above 0x00ff give 0xff.
//
// Backward path: every training forward pushes its derivative bit into a
// small FIFO. Each incoming error pops one bit in FIFO order. The error is
// passed through unchanged when that bit is 1, and replaced by zero when it
// is 0.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   train                 capture derivative bits on forward handshakes
//   argument_*            forward input,  16-bit signed Q8.8 (valid/ready)
//   result_*              forward output, 8-bit unsigned Q0.8 (valid/ready)
//   error_*               backward input, 16-bit signed Q8.8 (valid/ready)
//   propagate_*           backward output, 16-bit gated error (valid/ready)
module rectifier #(
  parameter int D = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        train,
  input  logic        argument_valid,
  output logic        argument_ready,
  input  logic [15:0] argument_data,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [7:0]  result_data,
  input  logic        error_valid,
  output logic        error_ready,
  input  logic [15:0] error_data,
  output logic        propagate_valid,
  input  logic        propagate_ready,
  output logic [15:0] propagate_data
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   count_t;

  logic         result_valid_q, result_valid_d;
  logic [7:0]   result_data_q, result_data_d;
  logic         propagate_valid_q, propagate_valid_d;
  logic [15:0]  propagate_data_q, propagate_data_d;
  ptr_t         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  count_t       count_q, count_d;
  logic [D-1:0] deriv_q, deriv_d;

  logic       neg, sat, deriv_bit;
  logic [7:0] act;
  logic       full, empty;
  logic       arg_fire, err_fire, push, pop;

  // The sign bit marks a negative input. Any set bit in [14:8] of a
  // non-negative input means the value is above 0x00ff.
  assign neg       = argument_data[15];
  assign sat       = !neg && (argument_data[14:8] != 7'd0);
  assign deriv_bit = !neg && !sat;
  assign act       = neg ? 8'h00 : (sat ? 8'hff : argument_data[7:0]);

  // D is a power of two and count never exceeds D, so the count's top bit
  // is set exactly when the queue is full.
  assign full  = count_q[AW];
  assign empty = (count_q == '0);

  assign argument_ready = (!result_valid_q || result_ready) && !(train && full);
  assign error_ready    = (!propagate_valid_q || propagate_ready) && !empty;

  assign arg_fire = argument_valid && argument_ready;
  assign err_fire = error_valid && error_ready;
  assign push     = arg_fire && train;
  assign pop      = err_fire;

  always_comb begin
    result_valid_d    = result_valid_q;
    result_data_d     = result_data_q;
    propagate_valid_d = propagate_valid_q;
    propagate_data_d  = propagate_data_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    count_d           = count_q;
    deriv_d           = deriv_q;

    if (arg_fire) begin
      result_valid_d = 1'b1;
      result_data_d  = act;
    end else if (result_ready) begin
      result_valid_d = 1'b0;
    end

    if (err_fire) begin
      propagate_valid_d = 1'b1;
      propagate_data_d  = deriv_q[rd_ptr_q] ? error_data : 16'h0000;
    end else if (propagate_ready) begin
      propagate_valid_d = 1'b0;
    end

    if (push) begin
      deriv_d[wr_ptr_q] = deriv_bit;
      wr_ptr_d          = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + count_t'(1);
      2'b01:   count_d = count_q - count_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_valid_q    <= 1'b0;
      result_data_q     <= 8'h00;
      propagate_valid_q <= 1'b0;
      propagate_data_q  <= 16'h0000;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      deriv_q           <= '0;
    end else begin
      result_valid_q    <= result_valid_d;
      result_data_q     <= result_data_d;
      propagate_valid_q <= propagate_valid_d;
      propagate_data_q  <= propagate_data_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      deriv_q           <= deriv_d;
    end
  end

  assign result_valid    = result_valid_q;
  assign result_data     = result_data_q;
  assign propagate_valid = propagate_valid_q;
  assign propagate_data  = propagate_data_q;

endmodule

// File: tb/tb_rectifier.sv
// tb_rectifier: drives directed sequences and random traffic into rectifier.
// A handshake-level reference model checks every cycle. The model holds the
// pending result, the pending propagate, and a queue of derivative bits.
module tb_rectifier;
  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        train = 1'b0;
  logic        argument_valid = 1'b0;
  logic        argument_ready;
  logic [15:0] argument_data = 16'h0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [7:0]  result_data;
  logic        error_valid = 1'b0;
  logic        error_ready;
  logic [15:0] error_data = 16'h0;
  logic        propagate_valid;
  logic        propagate_ready = 1'b0;
  logic [15:0] propagate_data;

  always #5 clock = ~clock;

  rectifier #(.D(D)) dut (
    .clock(clock), .reset(reset), .train(train),
    .argument_valid(argument_valid), .argument_ready(argument_ready),
    .argument_data(argument_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data),
    .error_valid(error_valid), .error_ready(error_ready),
    .error_data(error_data),
    .propagate_valid(propagate_valid), .propagate_ready(propagate_ready),
    .propagate_data(propagate_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit verbose  = 1'b1;

  // Reference model state
  bit          m_rv;
  logic [7:0]  m_rd;
  bit          m_pv;
  logic [15:0] m_pd;
  bit          m_q[$];

  // DUT outputs observed in the most recent cycle (before its rising edge)
  logic        o_ar, o_er, o_rv, o_pv;
  logic [7:0]  o_rd;
  logic [15:0] o_pd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] act_ref(input logic [15:0] a);
    int x;
    x = $signed(a);
    if (x < 0)   return 8'h00;
    if (x > 255) return 8'hff;
    return 8'(x);
  endfunction

  function automatic bit der_ref(input logic [15:0] a);
    int x;
    x = $signed(a);
    return (x >= 0) && (x <= 255);
  endfunction

  task automatic model_clear();
    m_rv = 1'b0; m_rd = 8'h00; m_pv = 1'b0; m_pd = 16'h0000;
    m_q.delete();
  endtask

  // One clock cycle. Inputs are driven at the falling edge, outputs are
  // compared shortly after, and the model advances at the rising edge.
  task automatic cycle(input logic av, input logic [15:0] ad, input logic rr,
                       input logic ev, input logic [15:0] ed, input logic pr,
                       input logic tr);
    bit a_rdy, e_rdy, a_fire, e_fire, bitv;
    @(negedge clock);
    argument_valid = av; argument_data = ad; result_ready = rr;
    error_valid = ev; error_data = ed; propagate_ready = pr; train = tr;
    #1;
    a_rdy = (!m_rv || rr) && !(tr && (m_q.size() == D));
    e_rdy = (!m_pv || pr) && (m_q.size() != 0);
    o_ar = argument_ready; o_er = error_ready; o_rv = result_valid;
    o_pv = propagate_valid; o_rd = result_data; o_pd = propagate_data;
    check("argument_ready", 32'(o_ar), 32'(a_rdy));
    check("error_ready", 32'(o_er), 32'(e_rdy));
    check("result_valid", 32'(o_rv), 32'(m_rv));
    if (m_rv) check("result_data", 32'(o_rd), 32'(m_rd));
    check("propagate_valid", 32'(o_pv), 32'(m_pv));
    if (m_pv) check("propagate_data", 32'(o_pd), 32'(m_pd));
    a_fire = av && a_rdy;
    e_fire = ev && e_rdy;
    @(posedge clock);
    if (e_fire) begin
      bitv = m_q.pop_front();
      m_pv = 1'b1;
      m_pd = bitv ? ed : 16'h0000;
      if (verbose) $display("err  0x%04h deriv=%0d -> propagate 0x%04h", ed, bitv, m_pd);
    end else if (pr) begin
      m_pv = 1'b0;
    end
    if (a_fire) begin
      if (tr) m_q.push_back(der_ref(ad));
      m_rv = 1'b1;
      m_rd = act_ref(ad);
      if (verbose) $display("fwd  0x%04h train=%0d -> result 0x%02h", ad, tr, m_rd);
    end else if (rr) begin
      m_rv = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  // Holds reset low for one cycle, checks the outputs while it is held,
  // then releases it at a falling edge.
  task automatic do_reset();
    @(negedge clock);
    argument_valid = 1'b0; error_valid = 1'b0; train = 1'b0;
    result_ready = 1'b0; propagate_ready = 1'b0;
    reset = 1'b0;
    model_clear();
    #1;
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_result_data", 32'(result_data), 32'd0);
    check("rst_propagate_valid", 32'(propagate_valid), 32'd0);
    check("rst_propagate_data", 32'(propagate_data), 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  logic [15:0] tp1_arg[5] = '{16'h0080, 16'hff80, 16'h0100, 16'h00ff, 16'h0000};
  logic [7:0]  tp1_exp[5] = '{8'h80, 8'h00, 8'hff, 8'hff, 8'h00};
  logic [15:0] tp2_arg[3] = '{16'h0040, 16'hfff0, 16'h0200};
  logic [15:0] tp2_err[3] = '{16'h0123, 16'hfe00, 16'h0050};
  logic [15:0] tp2_exp[3] = '{16'h0123, 16'h0000, 16'h0000};

  initial begin
    logic [15:0] a, e;
    int sel;

    // Inference mode: activation values, one cycle after each handshake
    do_reset();
    for (int i = 0; i <= 5; i++) begin
      cycle(i < 5, (i < 5) ? tp1_arg[i % 5] : 16'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
      if (i > 0) begin
        check("tp1_valid", 32'(o_rv), 32'd1);
        check("tp1_result", 32'(o_rd), 32'(tp1_exp[i - 1]));
      end
    end

    // Training forwards, then errors gated in FIFO order
    for (int i = 0; i < 3; i++) cycle(1'b1, tp2_arg[i], 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i <= 3; i++) begin
      cycle(i < 3, (i < 3) ? tp2_err[i % 3] : 16'h0, 1'b1, i < 3,
            (i < 3) ? tp2_err[i % 3] : 16'h0, 1'b1, 1'b0);
      if (i > 0) check("tp2_propagate", 32'(o_pd), 32'(tp2_exp[i - 1]));
    end
    idle(1);

    // Full queue blocks training forwards until one pop
    do_reset();
    for (int i = 0; i < D; i++) cycle(1'b1, 16'h0010 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    cycle(1'b1, 16'h0055, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    check("full_blocks_arg", 32'(o_ar), 32'd0);
    cycle(1'b1, 16'h0055, 1'b1, 1'b1, 16'h0777, 1'b1, 1'b1);
    check("full_pop_same_cycle", 32'(o_ar), 32'd0);
    cycle(1'b1, 16'h0055, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    check("after_pop_arg_ready", 32'(o_ar), 32'd1);
    for (int i = 0; i < D + 1; i++) cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);

    // Empty queue: errors stall
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
      check("empty_error_ready", 32'(o_er), 32'd0);
      check("empty_prop_valid", 32'(o_pv), 32'd0);
    end

    // Backpressure: first result held, second admitted when drained
    do_reset();
    cycle(1'b1, 16'h0011, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0022, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("bp_arg_ready", 32'(o_ar), 32'd0);
    check("bp_hold1", 32'(o_rd), 32'h11);
    cycle(1'b1, 16'h0022, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("bp_hold2", 32'(o_rd), 32'h11);
    cycle(1'b1, 16'h0022, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check("bp_first_out", 32'(o_rd), 32'h11);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check("bp_second_out", 32'(o_rd), 32'h22);
    check("bp_second_valid", 32'(o_rv), 32'd1);
    idle(1);

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_result_valid", 32'(result_valid), 32'd0);
    check("midrst_prop_valid", 32'(propagate_valid), 32'd0);
    model_clear();
    argument_valid = 1'b0; error_valid = 1'b0; train = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0abc, 1'b1, 1'b0);
    check("midrst_queue_empty", 32'(o_er), 32'd0);

    // Random traffic against the model
    verbose = 1'b0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       a = 16'($urandom);
        1:       a = 16'($urandom_range(0, 255));
        2:       a = 16'hff00 | 16'($urandom_range(0, 255));
        default: a = 16'($urandom_range(250, 260));
      endcase
      e = 16'($urandom);
      cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, e, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
